// File: rtl/xox_pkg.sv
// Shared types and constants for the XOX move arbiter and its board renderer.
// Latency: none (declarations and pure functions only).
// Backpressure: not applicable.
package xox_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        P1    = 2'd1,
        P2    = 2'd2
    } cell_t;

    typedef enum logic [1:0] {
        TURN_P1 = 2'd0,
        TURN_P2 = 2'd1,
        CHECK   = 2'd2,
        OVER    = 2'd3
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    // Byte lanes inside one 24-bit LED row word
    localparam int RED_LSB = 16;
    localparam int GRN_LSB = 8;
    localparam int BLU_LSB = 0;

    typedef logic [2:0][3:0] line_t;

    // Eight win lines as cell indices (row*3+col): rows, columns, diagonals
    localparam logic [7:0][2:0][3:0] WIN_LINES = {
        {4'd6, 4'd4, 4'd2},
        {4'd8, 4'd4, 4'd0},
        {4'd8, 4'd5, 4'd2},
        {4'd7, 4'd4, 4'd1},
        {4'd6, 4'd3, 4'd0},
        {4'd8, 4'd7, 4'd6},
        {4'd5, 4'd4, 4'd3},
        {4'd2, 4'd1, 4'd0}
    };

    // True when all three cells of a line hold the given player code
    function automatic logic line_owned(input logic [8:0][1:0] c,
                                        input line_t           line,
                                        input logic [1:0]      who);
        return (c[line[0]] == who) && (c[line[1]] == who) && (c[line[2]] == who);
    endfunction

    // True when the player owns any of the eight lines
    function automatic logic any_line(input logic [8:0][1:0] c,
                                      input logic [1:0]      who);
        logic hit;
        hit = 1'b0;
        for (int l = 0; l < 8; l++) begin
            if (line_owned(c, WIN_LINES[l], who)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

endpackage

// File: rtl/xox_board_render.sv
// Maps the 3x3 cell array and winner code onto an 8x8 RGB frame.
// Latency: purely combinational; the parent registers the result.
// Backpressure: none, the frame is recomputed every cycle.
module xox_board_render
    import xox_pkg::*;
(
    input  logic [8:0][1:0]  cells,
    input  logic [1:0]       winner,
    output logic [7:0][23:0] board
);

    logic [8:0] win_mask;
    logic [3:0] cidx;
    logic [7:0] red;
    logic [7:0] grn;
    logic [7:0] blu;

    // Mark every cell that belongs to a line owned by the declared winner
    always_comb begin
        win_mask = '0;
        if (winner == WIN_P1 || winner == WIN_P2) begin
            for (int l = 0; l < 8; l++) begin
                if (line_owned(cells, WIN_LINES[l], winner)) begin
                    for (int k = 0; k < 3; k++) begin
                        win_mask[WIN_LINES[l][k]] = 1'b1;
                    end
                end
            end
        end
    end

    // Paint grid lines green, cells in their player colour, winning line white
    always_comb begin
        board = '0;
        cidx  = '0;
        red   = '0;
        grn   = '0;
        blu   = '0;
        for (int pr = 0; pr < 8; pr++) begin
            red = '0;
            grn = '0;
            blu = '0;
            for (int pc = 0; pc < 8; pc++) begin
                if (pr == 2 || pr == 5 || pc == 2 || pc == 5) begin
                    grn[pc] = 1'b1;
                end else begin
                    cidx = 4'((pr / 3) * 3 + (pc / 3));
                    if (win_mask[cidx]) begin
                        red[pc] = 1'b1;
                        grn[pc] = 1'b1;
                        blu[pc] = 1'b1;
                    end else if (cells[cidx] == P1) begin
                        red[pc] = 1'b1;
                    end else if (cells[cidx] == P2) begin
                        blu[pc] = 1'b1;
                    end
                end
            end
            board[pr][RED_LSB +: 8] = red;
            board[pr][GRN_LSB +: 8] = grn;
            board[pr][BLU_LSB +: 8] = blu;
        end
    end

endmodule

// File: rtl/xox_move_arbiter.sv
// Turn arbiter and game-state owner for XOX: validates moves, detects win/draw, drives the LED frame.
// Latency: request high at N -> pulse/cell write at N+1, CHECK at N+2, turn/winner at N+3; board lags cells by 1.
// Backpressure: none; off-turn, mid-CHECK and post-game request edges are dropped, never queued.
module xox_move_arbiter
    import xox_pkg::*;
#(
    parameter int MAX_MOVES = 9
) (
    input  logic             basysClk,
    input  logic             resetN,
    input  logic             newGame,
    input  logic             p1Req,
    input  logic [1:0]       p1Row,
    input  logic [1:0]       p1Col,
    input  logic             p2Req,
    input  logic [1:0]       p2Row,
    input  logic [1:0]       p2Col,
    output logic [8:0][1:0]  cells,
    output logic             turn,
    output logic [1:0]       winner,
    output logic             gameOver,
    output logic             moveAccepted,
    output logic             moveRejected,
    output logic [7:0][23:0] board
);

    logic             p1_req_q, p1_req_qq;
    logic             p2_req_q, p2_req_qq;
    logic             p1_edge, p2_edge;

    state_t           state_q, state_d;
    logic             turn_q, turn_d;
    logic [1:0]       winner_q, winner_d;
    logic [3:0]       count_q, count_d;
    logic [8:0][1:0]  cells_q, cells_d;
    logic [7:0][23:0] board_q, board_d;

    logic             move_accepted, move_rejected;
    logic             on_edge;
    logic [1:0]       on_row, on_col;
    logic [1:0]       mover;
    logic [3:0]       target;
    logic             legal;

    // Two-stage request capture; an edge is a fresh high on the first stage
    always_ff @(posedge basysClk or negedge resetN) begin
        if (!resetN) begin
            p1_req_q  <= 1'b0;
            p1_req_qq <= 1'b0;
            p2_req_q  <= 1'b0;
            p2_req_qq <= 1'b0;
        end else begin
            p1_req_q  <= p1Req;
            p1_req_qq <= p1_req_q;
            p2_req_q  <= p2Req;
            p2_req_qq <= p2_req_q;
        end
    end

    assign p1_edge = p1_req_q & ~p1_req_qq;
    assign p2_edge = p2_req_q & ~p2_req_qq;

    // Game state, board contents and counters
    always_ff @(posedge basysClk or negedge resetN) begin
        if (!resetN) begin
            state_q  <= TURN_P1;
            turn_q   <= 1'b0;
            winner_q <= WIN_NONE;
            count_q  <= '0;
            cells_q  <= '0;
        end else begin
            state_q  <= state_d;
            turn_q   <= turn_d;
            winner_q <= winner_d;
            count_q  <= count_d;
            cells_q  <= cells_d;
        end
    end

    // Next-state logic: move validation in TURN states, line evaluation in CHECK
    always_comb begin
        state_d       = state_q;
        turn_d        = turn_q;
        winner_d      = winner_q;
        count_d       = count_q;
        cells_d       = cells_q;
        move_accepted = 1'b0;
        move_rejected = 1'b0;

        // Only the on-turn player's edge and coordinates are looked at
        on_edge = (state_q == TURN_P2) ? p2_edge : p1_edge;
        on_row  = (state_q == TURN_P2) ? p2Row   : p1Row;
        on_col  = (state_q == TURN_P2) ? p2Col   : p1Col;
        target  = {2'b00, on_row} * 4'd3 + {2'b00, on_col};
        legal   = (on_row <= 2'd2) && (on_col <= 2'd2);
        mover   = turn_q ? P2 : P1;

        if (newGame) begin
            state_d  = TURN_P1;
            turn_d   = 1'b0;
            winner_d = WIN_NONE;
            count_d  = '0;
            cells_d  = '0;
        end else begin
            case (state_q)
                TURN_P1, TURN_P2: begin
                    if (on_edge) begin
                        if (legal && cells_q[target] == EMPTY) begin
                            cells_d[target] = (state_q == TURN_P2) ? P2 : P1;
                            count_d         = (count_q >= 4'd9) ? 4'd9 : count_q + 4'd1;
                            move_accepted   = 1'b1;
                            state_d         = CHECK;
                        end else begin
                            move_rejected   = 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (any_line(cells_q, mover)) begin
                        state_d  = OVER;
                        winner_d = mover;
                    end else if (count_q == 4'(MAX_MOVES)) begin
                        state_d  = OVER;
                        winner_d = WIN_DRAW;
                    end else begin
                        state_d  = turn_q ? TURN_P1 : TURN_P2;
                        turn_d   = ~turn_q;
                    end
                end
                default: begin
                    state_d = OVER;
                end
            endcase
        end
    end

    xox_board_render u_render (
        .cells  (cells_q),
        .winner (winner_q),
        .board  (board_d)
    );

    // Registered frame so the matrix driver sees a glitch-free image
    always_ff @(posedge basysClk or negedge resetN) begin
        if (!resetN) begin
            board_q <= '0;
        end else begin
            board_q <= board_d;
        end
    end

    assign cells        = cells_q;
    assign turn         = turn_q;
    assign winner       = winner_q;
    assign gameOver     = (state_q == OVER);
    assign moveAccepted = move_accepted;
    assign moveRejected = move_rejected;
    assign board        = board_q;

endmodule
